// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair: duty mode codes,
// classification band constants and the capture FSM state type.
package pwm_pkg;

  localparam logic [1:0] MODE_80  = 2'b00;
  localparam logic [1:0] MODE_60  = 2'b01;
  localparam logic [1:0] MODE_40  = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  // Duty bands expressed as 20*high against k*period, bounds inclusive.
  localparam logic [4:0] BAND_80_LO = 5'd15;
  localparam logic [4:0] BAND_80_HI = 5'd17;
  localparam logic [4:0] BAND_60_LO = 5'd11;
  localparam logic [4:0] BAND_60_HI = 5'd13;
  localparam logic [4:0] BAND_40_LO = 5'd7;
  localparam logic [4:0] BAND_40_HI = 5'd9;
  localparam logic [4:0] DUTY_SCALE = 5'd20;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MEAS_HIGH = 2'b01,
    MEAS_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture: two-flop synchroniser, optional deglitch
// filter (macro PWM_CAPTURE_DEGLITCH_EN) and registered rise/fall strobes.
module pwm_edge_sync #(
  parameter int DEGLITCH_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic rise,
  output logic fall,
  output logic level
);

`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int FILT_CYC = FILT_EN ? DEGLITCH_CYC : 0;

  logic sync_p0;
  logic sync_p1;
  logic s;
  logic s_d;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pwm;
      sync_p1 <= sync_p0;
    end
  end

  generate
    if (FILT_CYC > 0) begin : g_deglitch
      localparam int CW = $clog2(FILT_CYC + 1);
      localparam logic [CW-1:0] RUN_LAST = CW'(FILT_CYC - 1);
      logic [CW-1:0] run;
      logic          filt;

      // Filter stage: adopt a new level only after FILT_CYC consecutive cycles
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          run  <= '0;
          filt <= 1'b0;
        end else if (sync_p1 == filt) begin
          run <= '0;
        end else if (run == RUN_LAST) begin
          run  <= '0;
          filt <= sync_p1;
        end else begin
          run <= run + CW'(1);
        end
      end

      assign s = filt;
    end else begin : g_bypass
      assign s = sync_p1;
    end
  endgenerate

  // Edge stage: registered one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s_d  <= s;
      rise <= s & ~s_d;
      fall <= ~s & s_d;
    end
  end

  assign level = s;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with duty classification and stuck-input
// timeout. Optional input deglitch enabled by macro PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W        = 21,
  parameter int TIMEOUT      = 2_000_000,
  parameter int DEGLITCH_CYC = 16
) (
  input  logic             ext_clk_25m,
  input  logic             ext_rst,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic [1:0]       o_mode,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  localparam int PW     = CNT_W + 5;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] per,
                                          input logic [CNT_W-1:0] hi);
    logic [PW-1:0] h20;
    logic [PW-1:0] p;
    h20 = PW'(hi) * PW'(DUTY_SCALE);
    p   = PW'(per);
    if (h20 >= p * PW'(BAND_80_LO) && h20 <= p * PW'(BAND_80_HI)) return MODE_80;
    if (h20 >= p * PW'(BAND_60_LO) && h20 <= p * PW'(BAND_60_HI)) return MODE_60;
    if (h20 >= p * PW'(BAND_40_LO) && h20 <= p * PW'(BAND_40_HI)) return MODE_40;
    return MODE_OFF;
  endfunction

  logic              rise;
  logic              fall;
  logic              level;
  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [CNT_W-1:0]  per_next;
  logic [CNT_W-1:0]  hi_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic              publish;
  logic              timeout_hit;

  pwm_edge_sync #(
    .DEGLITCH_CYC(DEGLITCH_CYC)
  ) u_edge (
    .clk  (ext_clk_25m),
    .rst  (ext_rst),
    .pwm  (i_pwm),
    .rise (rise),
    .fall (fall),
    .level(level)
  );

  always_comb begin
    state_next  = state;
    per_next    = per_cnt;
    hi_next     = hi_cnt;
    publish     = 1'b0;
    // An edge landing on the timeout cycle wins: the input is clearly alive.
    timeout_hit = !(rise || fall) && (idle_cnt == IDLE_LAST);
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = MEAS_HIGH;
          per_next   = CNT_ONE;
          hi_next    = CNT_ONE;
        end
      end
      MEAS_HIGH: begin
        per_next = sat_inc(per_cnt);
        if (fall) state_next = MEAS_LOW;
        else      hi_next    = sat_inc(hi_cnt);
      end
      MEAS_LOW: begin
        if (rise) begin
          publish    = 1'b1;
          state_next = MEAS_HIGH;
          per_next   = CNT_ONE;
          hi_next    = CNT_ONE;
        end else begin
          per_next = sat_inc(per_cnt);
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Measurement stage: period/high counters and edge-activity watchdog
  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) begin
      per_cnt  <= '0;
      hi_cnt   <= '0;
      idle_cnt <= '0;
    end else begin
      per_cnt <= per_next;
      hi_cnt  <= hi_next;
      if (rise || fall)          idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Output stage: publish on the rise that closes a period
  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) begin
      o_period  <= '0;
      o_high    <= '0;
      o_mode    <= MODE_OFF;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= publish;
      if (publish) begin
        o_period <= per_cnt;
        o_high   <= hi_cnt;
        o_mode   <= classify(per_cnt, hi_cnt);
      end
      if (timeout_hit) begin
        o_timeout <= 1'b1;
        o_mode    <= MODE_OFF;
      end else if (rise) begin
        o_timeout <= 1'b0;
      end
    end
  end

  assign o_level = level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (CNT_W=12, TIMEOUT=400,
// DEGLITCH_CYC=4); expectations follow PWM_CAPTURE_DEGLITCH_EN when defined.
module tb_pwm_capture;

  localparam int CNT_W        = 12;
  localparam int TIMEOUT      = 400;
  localparam int DEGLITCH_CYC = 4;
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int LAT = 4 + DEGLITCH_CYC;
`else
  localparam int LAT = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic [1:0]       o_mode;
  logic             o_valid;
  logic             o_timeout;
  logic             o_level;

  int n_cmp = 0;
  int n_err = 0;
  int vcount = 0;
  logic [CNT_W-1:0] cap_per [64];
  logic [CNT_W-1:0] cap_hi  [64];
  logic [1:0]       cap_mode[64];

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .DEGLITCH_CYC(DEGLITCH_CYC)
  ) dut (
    .ext_clk_25m(clk),
    .ext_rst    (rst),
    .i_pwm      (pwm),
    .o_period   (o_period),
    .o_high     (o_high),
    .o_mode     (o_mode),
    .o_valid    (o_valid),
    .o_timeout  (o_timeout),
    .o_level    (o_level)
  );

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (vcount < 64) begin
        cap_per[vcount]  <= o_period;
        cap_hi[vcount]   <= o_high;
        cap_mode[vcount] <= o_mode;
      end
      vcount <= vcount + 1;
    end
  end

  task automatic do_reset();
    pwm = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_period(input int per, input int hi);
    drive(1'b1, hi);
    drive(1'b0, per - hi);
  endtask

  task automatic finish_rise(output int lat);
    lat = -1;
    pwm = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1 && lat < 0) lat = i - 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_period !== 12'd0) begin n_err++; $display("FAIL reset_period got %0d want 0", o_period); end
    n_cmp++; if (o_high !== 12'd0) begin n_err++; $display("FAIL reset_high got %0d want 0", o_high); end
    n_cmp++; if (o_mode !== 2'b11) begin n_err++; $display("FAIL reset_mode got %b want 11", o_mode); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", o_timeout); end
    n_cmp++; if (o_level !== 1'b0) begin n_err++; $display("FAIL reset_level got %b want 0", o_level); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_duty80();
    int base;
    int lat;
    do_reset();
    base = vcount;
    pwm_period(100, 80);
    n_cmp++; if (vcount !== base) begin n_err++; $display("FAIL d80_no_valid_from_idle got %0d want %0d", vcount, base); end
    pwm_period(100, 80);
    pwm_period(100, 80);
    finish_rise(lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL d80_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (vcount - base !== 3) begin n_err++; $display("FAIL d80_count got %0d want 3", vcount - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (cap_per[base+i] !== 12'd100) begin n_err++; $display("FAIL d80_period[%0d] got %0d want 100", i, cap_per[base+i]); end
      n_cmp++; if (cap_hi[base+i] !== 12'd80) begin n_err++; $display("FAIL d80_high[%0d] got %0d want 80", i, cap_hi[base+i]); end
      n_cmp++; if (cap_mode[base+i] !== 2'b00) begin n_err++; $display("FAIL d80_mode[%0d] got %b want 00", i, cap_mode[base+i]); end
    end
  endtask

  task automatic test_duty60_40();
    int base;
    int lat;
    int exp_hi[4] = '{60, 60, 40, 40};
    logic [1:0] exp_mode[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    do_reset();
    base = vcount;
    pwm_period(100, 60);
    pwm_period(100, 60);
    pwm_period(100, 40);
    pwm_period(100, 40);
    finish_rise(lat);
    n_cmp++; if (vcount - base !== 4) begin n_err++; $display("FAIL d6040_count got %0d want 4", vcount - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cap_per[base+i] !== 12'd100) begin n_err++; $display("FAIL d6040_period[%0d] got %0d want 100", i, cap_per[base+i]); end
      n_cmp++; if (cap_hi[base+i] !== 12'(exp_hi[i])) begin n_err++; $display("FAIL d6040_high[%0d] got %0d want %0d", i, cap_hi[base+i], exp_hi[i]); end
      n_cmp++; if (cap_mode[base+i] !== exp_mode[i]) begin n_err++; $display("FAIL d6040_mode[%0d] got %b want %b", i, cap_mode[base+i], exp_mode[i]); end
    end
  endtask

  task automatic test_band_edges();
    int base;
    int lat;
    int exp_hi[3] = '{50, 75, 85};
    logic [1:0] exp_mode[3] = '{2'b11, 2'b00, 2'b00};
    do_reset();
    base = vcount;
    pwm_period(100, 50);
    pwm_period(100, 75);
    pwm_period(100, 85);
    finish_rise(lat);
    n_cmp++; if (vcount - base !== 3) begin n_err++; $display("FAIL band_count got %0d want 3", vcount - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (cap_per[base+i] !== 12'd100) begin n_err++; $display("FAIL band_period[%0d] got %0d want 100", i, cap_per[base+i]); end
      n_cmp++; if (cap_hi[base+i] !== 12'(exp_hi[i])) begin n_err++; $display("FAIL band_high[%0d] got %0d want %0d", i, cap_hi[base+i], exp_hi[i]); end
      n_cmp++; if (cap_mode[base+i] !== exp_mode[i]) begin n_err++; $display("FAIL band_mode[%0d] got %b want %b", i, cap_mode[base+i], exp_mode[i]); end
    end
  endtask

  task automatic test_timeout();
    int base;
    int lat;
    do_reset();
    pwm_period(100, 80);
    pwm_period(100, 80);
    finish_rise(lat);
    base = vcount;
    drive(1'b0, 390);
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL to_early got %b want 0", o_timeout); end
    drive(1'b0, 30);
    n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag got %b want 1", o_timeout); end
    n_cmp++; if (o_mode !== 2'b11) begin n_err++; $display("FAIL to_mode got %b want 11", o_mode); end
    n_cmp++; if (o_level !== 1'b0) begin n_err++; $display("FAIL to_level got %b want 0", o_level); end
    n_cmp++; if (o_period !== 12'd100) begin n_err++; $display("FAIL to_period_hold got %0d want 100", o_period); end
    n_cmp++; if (o_high !== 12'd80) begin n_err++; $display("FAIL to_high_hold got %0d want 80", o_high); end
    n_cmp++; if (vcount !== base) begin n_err++; $display("FAIL to_no_valid got %0d want %0d", vcount, base); end
    drive(1'b1, 10);
    n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL to_clear got %b want 0", o_timeout); end
    drive(1'b1, 70);
    drive(1'b0, 20);
    n_cmp++; if (vcount !== base) begin n_err++; $display("FAIL to_restart_no_valid got %0d want %0d", vcount, base); end
    finish_rise(lat);
    n_cmp++; if (vcount - base !== 1) begin n_err++; $display("FAIL to_restart_count got %0d want 1", vcount - base); end
    n_cmp++; if (cap_per[base] !== 12'd100 || cap_hi[base] !== 12'd80 || cap_mode[base] !== 2'b00) begin
      n_err++; $display("FAIL to_restart_meas got %0d/%0d/%b want 100/80/00", cap_per[base], cap_hi[base], cap_mode[base]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int lat;
    do_reset();
    pwm_period(100, 80);
    drive(1'b1, 80);
    drive(1'b0, 10);
    n_cmp++; if (o_period !== 12'd100) begin n_err++; $display("FAIL rm_pre_period got %0d want 100", o_period); end
    rst = 1'b1;
    #1;
    n_cmp++; if (o_period !== 12'd0) begin n_err++; $display("FAIL rm_period got %0d want 0", o_period); end
    n_cmp++; if (o_high !== 12'd0) begin n_err++; $display("FAIL rm_high got %0d want 0", o_high); end
    n_cmp++; if (o_mode !== 2'b11) begin n_err++; $display("FAIL rm_mode got %b want 11", o_mode); end
    n_cmp++; if (o_valid !== 1'b0 || o_timeout !== 1'b0 || o_level !== 1'b0) begin
      n_err++; $display("FAIL rm_flags got v%b t%b l%b want 000", o_valid, o_timeout, o_level);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    drive(1'b0, 10);
    base = vcount;
    pwm_period(100, 80);
    n_cmp++; if (vcount !== base) begin n_err++; $display("FAIL rm_no_valid got %0d want %0d", vcount, base); end
    finish_rise(lat);
    n_cmp++; if (vcount - base !== 1) begin n_err++; $display("FAIL rm_count got %0d want 1", vcount - base); end
    n_cmp++; if (cap_per[base] !== 12'd100 || cap_hi[base] !== 12'd80) begin
      n_err++; $display("FAIL rm_meas got %0d/%0d want 100/80", cap_per[base], cap_hi[base]);
    end
  endtask

  task automatic test_glitch();
    int base;
    int lat;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int NV = 2;
    int exp_per[4] = '{100, 100, 0, 0};
    int exp_hi[4]  = '{80, 80, 0, 0};
    logic [1:0] exp_mode[4] = '{2'b00, 2'b00, 2'b00, 2'b00};
`else
    localparam int NV = 4;
    int exp_per[4] = '{33, 67, 33, 67};
    int exp_hi[4]  = '{30, 47, 30, 47};
    logic [1:0] exp_mode[4] = '{2'b11, 2'b11, 2'b11, 2'b11};
`endif
    do_reset();
    base = vcount;
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, 30);
      drive(1'b0, 3);
      drive(1'b1, 47);
      drive(1'b0, 20);
    end
    finish_rise(lat);
    n_cmp++; if (vcount - base !== NV) begin n_err++; $display("FAIL glitch_count got %0d want %0d", vcount - base, NV); end
    for (int i = 0; i < NV; i++) begin
      n_cmp++; if (cap_per[base+i] !== 12'(exp_per[i])) begin n_err++; $display("FAIL glitch_period[%0d] got %0d want %0d", i, cap_per[base+i], exp_per[i]); end
      n_cmp++; if (cap_hi[base+i] !== 12'(exp_hi[i])) begin n_err++; $display("FAIL glitch_high[%0d] got %0d want %0d", i, cap_hi[base+i], exp_hi[i]); end
      n_cmp++; if (cap_mode[base+i] !== exp_mode[i]) begin n_err++; $display("FAIL glitch_mode[%0d] got %b want %b", i, cap_mode[base+i], exp_mode[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    pwm = 1'b0;
    test_reset();
    test_duty80();
    test_duty60_40();
    test_band_edges();
    test_timeout();
    test_reset_mid();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
